bus_port_fifo: RTL

- Per-device port adapter between one device (agent/driver side) and one port of the bus generator/arbiter `bs_gnrtr_n_rbtr`.
- TX path: buffers packets from the device and presents them to the bus through the pndng/pop/D_pop handshake.
- RX path: captures packets the bus delivers via push/D_push and buffers them for the device to read.
- One instance per bus port (`drvrs` instances).

---
 rtl/bus_port_pkg.sv | 24 ++
 rtl/port_sync_fifo.sv | 124 ++++++++++++
 rtl/bus_port_fifo.sv | 83 ++++++++
 3 files changed

// File: rtl/bus_port_pkg.sv
// Shared definitions for the bus port adapter: packet type, destination-ID
// field position and the broadcast ID. Packet contents are never modified by
// the adapter; these are provided so devices and checkers agree on the layout.
package bus_port_pkg;

  // Default packet width in bits; the destination ID occupies the top byte.
  localparam int PKT_W = 16;

  // Destination ID field bounds inside a packet.
  localparam int ID_HI = PKT_W - 1;
  localparam int ID_LO = PKT_W - 8;

  // Destination ID that addresses every device on the bus.
  localparam logic [7:0] BCAST_ID = 8'hFF;

  // Packet vector as seen on the bus.
  typedef logic [PKT_W-1:0] pkt_t;

  // Extract the destination ID from a packet.
  function automatic logic [7:0] pkt_dest_id(input pkt_t pkt);
    return pkt[ID_HI:ID_LO];
  endfunction

endpackage

// File: rtl/port_sync_fifo.sv
// Single-clock show-ahead FIFO used for both directions of the bus port.
// The head entry is presented combinationally from registered state, so the
// read data never depends on the same-cycle read or write strobes. While the
// FIFO is empty the read data is forced to zero. Writes that arrive while the
// FIFO is full (and no read frees a slot in the same cycle) are dropped and
// counted in a saturating counter.
module port_sync_fifo
  import bus_port_pkg::*;
#(
  parameter int DW    = PKT_W,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr,
  input  logic [DW-1:0]              i_wr_data,
  input  logic                       i_rd,
  output logic [DW-1:0]              o_rd_data,
  output logic                       o_not_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [CNT_W-1:0]           o_drop_cnt
);

  // Pointer width covers 0..DEPTH-1; depth need not be a power of two.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage: no reset, contents are meaningless until written.
  logic [DW-1:0]    r_mem [DEPTH];

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_empty;
  logic             w_full;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_drop;
  logic             w_drop_sat;

  // Pointer increment that wraps at DEPTH-1 rather than at a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == LAST_IDX) ? '0 : ptr + PW'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);

  // A read only counts when there is something to read. A write is accepted
  // when there is room, or when a same-cycle read frees the slot it needs;
  // this lets a full FIFO stream at one entry per cycle without drops.
  assign w_rd_ok    = i_rd & ~w_empty;
  assign w_wr_ok    = i_wr & (~w_full | w_rd_ok);
  assign w_drop     = i_wr & ~w_wr_ok;
  assign w_drop_sat = &r_drop_cnt;

  // Store accepted writes at the write pointer.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Advance the write pointer on every accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_wr_ok) begin
      r_wr_ptr <= ptr_inc(r_wr_ptr);
    end
  end

  // Advance the read pointer on every read of a non-empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_rd_ok) begin
      r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // Occupancy: +1 on write only, -1 on read only, unchanged when both or neither.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of writes lost to a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && !w_drop_sat) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  // Show-ahead head entry, masked to zero while empty so stale storage never
  // leaks out (including immediately after reset).
  always_comb begin
    o_rd_data = '0;
    if (!w_empty) begin
      o_rd_data = r_mem[r_rd_ptr];
    end
  end

  assign o_not_empty = ~w_empty;
  assign o_full      = w_full;
  assign o_count     = r_count;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: rtl/bus_port_fifo.sv
// Per-device adapter for one port of the bus generator/arbiter.
// TX: the device writes packets; the bus sees pndng/D_pop and consumes with pop.
// RX: the bus delivers packets with push/D_push; the device reads with rx_rd.
// Both directions use the same show-ahead FIFO; this level is wiring only.
module bus_port_fifo
  import bus_port_pkg::*;
#(
  parameter int pckg_sz = PKT_W,
  parameter int depth   = 8,
  parameter int cnt_w   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  // device -> bus
  input  logic                       tx_wr,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_full,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  // bus -> device
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rx_rd,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_valid,
  output logic [$clog2(depth+1)-1:0] rx_count,
  // loss statistics
  output logic [cnt_w-1:0]           tx_drop_cnt,
  output logic [cnt_w-1:0]           rx_drop_cnt
);

  // One active-low reset net feeds both directions so a mid-operation reset
  // empties both FIFOs together; pndng drops as soon as reset asserts because
  // it is decoded from the asynchronously cleared occupancy.
  logic w_rst_n;
  logic w_rx_full;

  assign w_rst_n = reset;

  // TX direction: device writes, bus pops.
  port_sync_fifo #(
    .DW    (pckg_sz),
    .DEPTH (depth),
    .CNT_W (cnt_w)
  ) u_tx_fifo (
    .clk         (clk),
    .rst_n       (w_rst_n),
    .i_wr        (tx_wr),
    .i_wr_data   (tx_data),
    .i_rd        (pop),
    .o_rd_data   (D_pop),
    .o_not_empty (pndng),
    .o_full      (tx_full),
    .o_count     (tx_count),
    .o_drop_cnt  (tx_drop_cnt)
  );

  // RX direction: bus pushes, device reads. The full flag is not a port; the
  // drop counter reports any overflow instead.
  port_sync_fifo #(
    .DW    (pckg_sz),
    .DEPTH (depth),
    .CNT_W (cnt_w)
  ) u_rx_fifo (
    .clk         (clk),
    .rst_n       (w_rst_n),
    .i_wr        (push),
    .i_wr_data   (D_push),
    .i_rd        (rx_rd),
    .o_rd_data   (rx_data),
    .o_not_empty (rx_valid),
    .o_full      (w_rx_full),
    .o_count     (rx_count),
    .o_drop_cnt  (rx_drop_cnt)
  );

  // Full state of the RX FIFO is only observable through rx_count.
  logic w_unused;
  assign w_unused = w_rx_full;

endmodule
